// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the byte-serial memory arbiter: state and
// sequencer-mode encodings, access lengths and the IO address window check.
package mem_arbiter_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] IO_ADDR_BASE = 32'h0003_0000;
  localparam logic [ADDR_WIDTH-1:0] IO_SPAN      = 32'd8;
  localparam int FETCH_BYTES = 4;

  localparam logic [2:0] LEN_1 = 3'd1;
  localparam logic [2:0] LEN_2 = 3'd2;
  localparam logic [2:0] LEN_4 = 3'd4;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF_RD,
    ST_LS_RD,
    ST_LS_WR,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RD,
    SEQ_WR
  } seq_mode_e;

  // Offset compare keeps the window correct under 32-bit wrap-around.
  function automatic logic is_io(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - IO_ADDR_BASE;
    return off < IO_SPAN;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and RAM-side signals of the arbiter; slave is the arbiter's
// view, master the view of whatever drives the requests and the RAM data.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
  ();

  logic                  if_req_valid;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [31:0]           if_data;

  logic                  ls_req_valid;
  logic                  ls_is_write;
  logic [2:0]            ls_len;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [31:0]           ls_wdata;
  logic                  ls_done;
  logic [31:0]           ls_rdata;

  logic                  misbranch_flag;
  logic                  io_buffer_full;

  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;

  modport slave (
    input  if_req_valid, if_addr, ls_req_valid, ls_is_write, ls_len, ls_addr,
           ls_wdata, misbranch_flag, io_buffer_full, mem_din,
    output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req_valid, if_addr, ls_req_valid, ls_is_write, ls_len, ls_addr,
           ls_wdata, misbranch_flag, io_buffer_full, mem_din,
    input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_byte_seq.sv
// Byte sequencer: walks the address, shifts write bytes out and read bytes in,
// and flags the edge on which the current transfer completes.
module mem_byte_seq
  import mem_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  seq_mode_e             mode_i,
  input  logic                  start_i,
  input  logic                  start_write_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            len_i,
  input  logic [31:0]           wdata_i,
  input  logic                  abort_i,
  input  logic                  io_full_i,
  input  logic [7:0]            mem_din_i,
  output logic                  finish_o,
  output logic [31:0]           word_o,
  output logic [ADDR_WIDTH-1:0] mem_a_o,
  output logic [7:0]            mem_dout_o,
  output logic                  mem_wr_o
);

  // cnt_q counts addresses issued; a read keeps counting past len so the
  // RAM's one-cycle latency drains before completion.
  logic [2:0]            cnt_q;
  logic [2:0]            len_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic [ADDR_WIDTH-1:0] mem_a_q;
  logic [7:0]            mem_dout_q;
  logic                  mem_wr_q;

  logic [2:0] rd_off;
  logic [1:0] rd_idx;
  logic [1:0] wr_idx;
  logic       start_throttle;
  logic       wr_throttle;

  assign rd_off         = cnt_q - 3'd2;
  assign rd_idx         = rd_off[1:0];
  assign wr_idx         = cnt_q[1:0];
  assign start_throttle = start_write_i && io_full_i && is_io(addr_i);
  assign wr_throttle    = io_full_i && is_io(base_q);

  assign finish_o = ((mode_i == SEQ_RD) && (cnt_q == len_q + 3'd1)) ||
                    ((mode_i == SEQ_WR) && (cnt_q == len_q));

  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    word_o = rdata_q;
    word_o[{rd_idx, 3'b000} +: 8] = mem_din_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      len_q      <= '0;
      base_q     <= '0;
      wdata_q    <= ZERO_WORD;
      rdata_q    <= ZERO_WORD;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= FALSE;
    end else if (en_i) begin
      if (start_i) begin
        base_q  <= addr_i;
        len_q   <= len_i;
        wdata_q <= wdata_i;
        rdata_q <= ZERO_WORD;
        if (start_throttle) begin
          cnt_q    <= '0;
          mem_a_q  <= '0;
          mem_wr_q <= FALSE;
        end else begin
          cnt_q      <= 3'd1;
          mem_a_q    <= addr_i;
          mem_dout_q <= start_write_i ? wdata_i[7:0] : 8'h00;
          mem_wr_q   <= start_write_i;
        end
      end else begin
        unique case (mode_i)
          SEQ_RD: begin
            mem_wr_q <= FALSE;
            if (abort_i) begin
              cnt_q   <= '0;
              mem_a_q <= '0;
            end else begin
              cnt_q   <= cnt_q + 3'd1;
              mem_a_q <= (cnt_q < len_q) ? base_q + ADDR_WIDTH'(cnt_q) : '0;
              if (cnt_q >= 3'd2) rdata_q[{rd_idx, 3'b000} +: 8] <= mem_din_i;
            end
          end
          SEQ_WR: begin
            if (cnt_q == len_q) begin
              mem_wr_q <= FALSE;
              mem_a_q  <= '0;
            end else if (wr_throttle) begin
              mem_wr_q <= FALSE;
            end else begin
              mem_a_q    <= base_q + ADDR_WIDTH'(cnt_q);
              mem_dout_q <= wdata_q[{wr_idx, 3'b000} +: 8];
              mem_wr_q   <= TRUE;
              cnt_q      <= cnt_q + 3'd1;
            end
          end
          default: begin
            cnt_q    <= '0;
            mem_a_q  <= '0;
            mem_wr_q <= FALSE;
          end
        endcase
      end
    end
  end

  assign mem_a_o    = mem_a_q;
  assign mem_dout_o = mem_dout_q;
  assign mem_wr_o   = mem_wr_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO port between instruction fetch and the LSU;
// the LSU wins arbitration, speculative reads abort on misbranch.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  mem_arbiter_if.slave  bus
);

  state_e      state_q;
  logic        if_done_q;
  logic        ls_done_q;
  logic [31:0] if_data_q;
  logic [31:0] ls_rdata_q;

  logic                  accept_ls;
  logic                  accept_if;
  logic                  start;
  logic                  start_write;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [2:0]            start_len;
  seq_mode_e             seq_mode;
  logic                  finish;
  logic [31:0]           word;
  logic                  mem_wr_q;

  // During a misbranch only stores may start; speculative reads must wait.
  assign accept_ls   = (state_q == ST_IDLE) && bus.ls_req_valid &&
                       (bus.ls_is_write || !bus.misbranch_flag);
  assign accept_if   = (state_q == ST_IDLE) && !bus.ls_req_valid &&
                       bus.if_req_valid && !bus.misbranch_flag;
  assign start       = accept_ls || accept_if;
  assign start_write = accept_ls && bus.ls_is_write;
  assign start_addr  = accept_ls ? bus.ls_addr : bus.if_addr;
  assign start_len   = accept_ls ? bus.ls_len : 3'(FETCH_BYTES);

  assign seq_mode = (state_q == ST_IF_RD || state_q == ST_LS_RD) ? SEQ_RD :
                    (state_q == ST_LS_WR) ? SEQ_WR : SEQ_IDLE;

  mem_byte_seq u_seq (
    .clk           (clk),
    .rst           (rst),
    .en_i          (rdy),
    .mode_i        (seq_mode),
    .start_i       (start),
    .start_write_i (start_write),
    .addr_i        (start_addr),
    .len_i         (start_len),
    .wdata_i       (bus.ls_wdata),
    .abort_i       (bus.misbranch_flag),
    .io_full_i     (bus.io_buffer_full),
    .mem_din_i     (bus.mem_din),
    .finish_o      (finish),
    .word_o        (word),
    .mem_a_o       (bus.mem_a),
    .mem_dout_o    (bus.mem_dout),
    .mem_wr_o      (mem_wr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      if_done_q  <= FALSE;
      ls_done_q  <= FALSE;
      if_data_q  <= ZERO_WORD;
      ls_rdata_q <= ZERO_WORD;
    end else if (rdy) begin
      if_done_q <= FALSE;
      ls_done_q <= FALSE;
      unique case (state_q)
        ST_IDLE: begin
          if (accept_ls)      state_q <= bus.ls_is_write ? ST_LS_WR : ST_LS_RD;
          else if (accept_if) state_q <= ST_IF_RD;
        end
        ST_IF_RD: begin
          if (bus.misbranch_flag) begin
            state_q <= ST_IDLE;
          end else if (finish) begin
            state_q   <= ST_DONE;
            if_done_q <= TRUE;
            if_data_q <= word;
          end
        end
        ST_LS_RD: begin
          if (bus.misbranch_flag) begin
            state_q <= ST_IDLE;
          end else if (finish) begin
            state_q    <= ST_DONE;
            ls_done_q  <= TRUE;
            ls_rdata_q <= word;
          end
        end
        ST_LS_WR: begin
          if (finish) begin
            state_q   <= ST_DONE;
            ls_done_q <= TRUE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.if_done  = if_done_q;
  assign bus.if_data  = if_data_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.mem_wr   = mem_wr_q && rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected completions and RAM
// writes into queues; a negedge monitor pops and compares as the DUT emits them.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    logic        is_ls;
    logic        chk_data;
    logic [31:0] data;
    int          cyc;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  dat;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  done_t done_q[$];
  wr_t   wr_q[$];
  logic [7:0] ram [logic [31:0]];

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  // RAM model: one-cycle read latency, clock-enabled by the global rdy.
  always @(posedge clk) if (rdy) bus.mem_din <= ram_rd(bus.mem_a);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input logic is_ls, input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step(1);
      got = is_ls ? bus.ls_done : bus.if_done;
    end
    check(is_ls ? "ls_done seen" : "if_done seen", {31'b0, got}, 32'd1);
  endtask

  task automatic push_done(input logic is_ls, input logic chk, input logic [31:0] d, input int c);
    done_t e;
    e.is_ls = is_ls; e.chk_data = chk; e.data = d; e.cyc = c;
    done_q.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d, input int c);
    wr_t e;
    e.addr = a; e.dat = d; e.cyc = c;
    wr_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      done_t de;
      wr_t   we;
      check("done exclusive", {31'b0, bus.if_done & bus.ls_done}, 32'd0);
      if (rdy && (bus.if_done || bus.ls_done)) begin
        if (done_q.size() == 0) begin
          check("unexpected done", 32'(done_q.size()), 32'd1);
        end else begin
          de = done_q.pop_front();
          check("done port", {31'b0, bus.ls_done}, {31'b0, de.is_ls});
          check("done cycle", 32'(cyc), 32'(de.cyc));
          if (de.chk_data)
            check("done data", bus.ls_done ? bus.ls_rdata : bus.if_data, de.data);
        end
      end
      if (bus.mem_wr) begin
        if (wr_q.size() == 0) begin
          check("unexpected write", 32'(wr_q.size()), 32'd1);
        end else begin
          we = wr_q.pop_front();
          check("write addr", bus.mem_a, we.addr);
          check("write byte", {24'b0, bus.mem_dout}, {24'b0, we.dat});
          check("write cycle", 32'(cyc), 32'(we.cyc));
        end
      end
    end
  end

  initial begin
    int e0;
    rst = 1'b1; rdy = 1'b1;
    bus.mem_din = 8'h00;
    bus.if_req_valid = 1'b0; bus.if_addr = '0;
    bus.ls_req_valid = 1'b0; bus.ls_is_write = 1'b0; bus.ls_len = '0;
    bus.ls_addr = '0; bus.ls_wdata = '0;
    bus.misbranch_flag = 1'b0; bus.io_buffer_full = 1'b0;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h20] = 8'hAA;   ram[32'h21] = 8'hBB;
    ram[32'h100] = 8'h11;  ram[32'h101] = 8'h22;  ram[32'h102] = 8'h33;  ram[32'h103] = 8'h44;

    step(2);
    check("reset mem_a", bus.mem_a, 32'h0);
    check("reset mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    check("reset mem_dout", {24'b0, bus.mem_dout}, 32'd0);
    check("reset if_done", {31'b0, bus.if_done}, 32'd0);
    check("reset ls_done", {31'b0, bus.ls_done}, 32'd0);
    check("reset if_data", bus.if_data, 32'h0);
    check("reset ls_rdata", bus.ls_rdata, 32'h0);
    rst = 1'b0;
    step(1);

    // Fetch 0x1000: address walk then done five edges after acceptance.
    e0 = cyc + 1;
    push_done(1'b0, 1'b1, 32'h0000_0513, e0 + 5);
    bus.if_req_valid = 1'b1; bus.if_addr = 32'h1000;
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("fetch mem_a", bus.mem_a, 32'h1000 + 32'(k));
    end
    step(1);
    check("fetch mem_a after last", bus.mem_a, 32'h0);
    wait_done(1'b0, 10);
    bus.if_req_valid = 1'b0;
    step(1);

    // Simultaneous requests: 2-byte load wins, fetch follows after DONE.
    e0 = cyc + 1;
    push_done(1'b1, 1'b1, 32'h0000_BBAA, e0 + 3);
    push_done(1'b0, 1'b1, 32'h0000_0513, e0 + 10);
    bus.if_req_valid = 1'b1; bus.if_addr = 32'h1000;
    bus.ls_req_valid = 1'b1; bus.ls_is_write = 1'b0; bus.ls_len = LEN_2; bus.ls_addr = 32'h20;
    wait_done(1'b1, 10);
    bus.ls_req_valid = 1'b0;
    wait_done(1'b0, 20);
    bus.if_req_valid = 1'b0;
    step(1);

    // 4-byte store of 0xDEADBEEF to 0x40.
    e0 = cyc + 1;
    push_wr(32'h40, 8'hEF, e0);
    push_wr(32'h41, 8'hBE, e0 + 1);
    push_wr(32'h42, 8'hAD, e0 + 2);
    push_wr(32'h43, 8'hDE, e0 + 3);
    push_done(1'b1, 1'b0, 32'h0, e0 + 4);
    bus.ls_req_valid = 1'b1; bus.ls_is_write = 1'b1; bus.ls_len = LEN_4;
    bus.ls_addr = 32'h40; bus.ls_wdata = 32'hDEAD_BEEF;
    wait_done(1'b1, 10);
    bus.ls_req_valid = 1'b0;
    step(1);

    // 1-byte IO store held off by io_buffer_full for three edges.
    e0 = cyc + 1;
    push_wr(32'h3_0000, 8'h5A, e0 + 3);
    push_done(1'b1, 1'b0, 32'h0, e0 + 4);
    bus.ls_req_valid = 1'b1; bus.ls_is_write = 1'b1; bus.ls_len = LEN_1;
    bus.ls_addr = 32'h3_0000; bus.ls_wdata = 32'h1234_565A;
    bus.io_buffer_full = 1'b1;
    step(3);
    bus.io_buffer_full = 1'b0;
    wait_done(1'b1, 10);
    bus.ls_req_valid = 1'b0;
    step(1);

    // Misbranch in the second fetch cycle aborts it with no done pulse.
    bus.if_req_valid = 1'b1; bus.if_addr = 32'h2000;
    step(1);
    check("abort fetch mem_a0", bus.mem_a, 32'h2000);
    step(1);
    check("abort fetch mem_a1", bus.mem_a, 32'h2001);
    bus.misbranch_flag = 1'b1;
    step(1);
    check("abort mem_a cleared", bus.mem_a, 32'h0);
    bus.if_req_valid = 1'b0;
    // A load is refused while the flag is high.
    bus.ls_req_valid = 1'b1; bus.ls_is_write = 1'b0; bus.ls_len = LEN_1; bus.ls_addr = 32'h20;
    step(1);
    check("load refused on misbranch", bus.mem_a, 32'h0);
    bus.ls_req_valid = 1'b0;

    // A store is accepted and completes with the flag still high.
    e0 = cyc + 1;
    push_wr(32'h80, 8'h88, e0);
    push_wr(32'h81, 8'h77, e0 + 1);
    push_done(1'b1, 1'b0, 32'h0, e0 + 2);
    bus.ls_req_valid = 1'b1; bus.ls_is_write = 1'b1; bus.ls_len = LEN_2;
    bus.ls_addr = 32'h80; bus.ls_wdata = 32'h0000_7788;
    wait_done(1'b1, 10);
    bus.ls_req_valid = 1'b0;
    bus.misbranch_flag = 1'b0;
    step(1);

    // rdy low for two edges mid-load delays completion by exactly two.
    e0 = cyc + 1;
    push_done(1'b1, 1'b1, 32'h4433_2211, e0 + 7);
    bus.ls_req_valid = 1'b1; bus.ls_is_write = 1'b0; bus.ls_len = LEN_4; bus.ls_addr = 32'h100;
    step(1);
    check("freeze load mem_a0", bus.mem_a, 32'h100);
    step(1);
    check("freeze load mem_a1", bus.mem_a, 32'h101);
    rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step(1);
      check("frozen mem_a", bus.mem_a, 32'h101);
      check("frozen mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    end
    rdy = 1'b1;
    wait_done(1'b1, 10);
    bus.ls_req_valid = 1'b0;
    step(2);

    check("done queue drained", 32'(done_q.size()), 32'd0);
    check("write queue drained", 32'(wr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
